cam_match_iterator: RTL
=======================

// Module: cam_match_iterator
// PURPOSE
//  Downstream consumer of the CAM array's decoded match vector (one bit per CAM row, multi-hot).
//  Accepts one match vector per transaction and emits every matching row index as a binary address,
//  lowest index first, one beat per valid/ready handshake, flagging the final beat.
//  A zero vector produces a single miss beat. Feeds the result/readout logic behind the CAM.
// PARAMETERS
//  CAM_DEPTH   8  number of CAM rows = width of match_vec
//  ADDR_WIDTH  3  width of out_addr; must satisfy 2**ADDR_WIDTH >= CAM_DEPTH
// PORTS
//  clk          in   1               single clock, all state on rising edge
//  rst          in   1               asynchronous, active-low reset
//  in_valid     in   1               match_vec valid
//  in_ready     out  1               block can accept a vector this cycle
//  match_vec    in   CAM_DEPTH       decoded match vector; bit i = row i matched
//  out_valid    out  1               out_addr/out_hit/out_last valid
//  out_ready    in   1               consumer accepts current beat
//  out_addr     out  ADDR_WIDTH      index of lowest still-pending match bit
//  out_hit      out  1               1 = real match, 0 = miss beat
//  out_last     out  1               final beat of this vector
//  match_count  out  ADDR_WIDTH+1    (MATCH_COUNT_EN only) popcount of accepted vector
// BEHAVIOUR
//  - State: IDLE, SCAN. Registers: state, pending[CAM_DEPTH-1:0], miss flag (+count).
//  - Reset (rst=0, async): state=IDLE, pending=0, count=0 -> out_valid=0, out_hit=0, out_addr=0,
//    out_last=0, in_ready=1 once rst released. Reset mid-SCAN abandons the vector; no further beats.
//  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last). Accept = in_valid & in_ready.
//  - Accept: pending<=match_vec, miss<=(match_vec==0), state<=SCAN. out_valid rises next cycle
//    (1-cycle latency edge to first beat). match_vec ignored when not accepted.
//  - SCAN: out_valid=1; out_addr = index of lowest set bit of pending (0 if pending==0);
//    out_hit = |pending; out_last = (popcount(pending) <= 1). Outputs decode from registers only
//    (no combinational path from inputs); stable while out_valid & ~out_ready.
//  - Beat handshake (out_valid & out_ready): clear bit out_addr of pending; if out_last:
//    state<=IDLE, unless a new vector is accepted in the same cycle -> reload pending, stay SCAN.
//  - Miss: zero vector -> exactly one beat, out_hit=0, out_addr=0, out_last=1.
//  - Beats per vector = max(1, popcount). Back-to-back vectors: no bubble between last beat and
//    next vector's first beat.
//  - IDLE: out_valid=0 and out_addr/out_hit/out_last driven 0.
//  - Highest row CAM_DEPTH-1 and all-ones vectors handled identically; no wrap, ascending order only.
// CONFIGURATION
//  MATCH_COUNT_EN defined: match_count port present; registered popcount of match_vec loaded on
//    accept, held constant for every beat of that vector, 0 after reset and in IDLE.
//  MATCH_COUNT_EN undefined: match_count port and popcount logic absent; all other behaviour identical.
// TESTING
//  1 match_vec=8'b1010_0100, out_ready=1 -> beats addr 2,5,7; out_hit=1 each; out_last only on 7.
//  2 match_vec=8'h00 -> one beat addr=0, out_hit=0, out_last=1; then out_valid=0, in_ready=1.
//  3 match_vec=8'h03, out_ready=0 for 3 cycles -> addr=0 held stable, in_ready=0; then beats 0,1(last).
//  4 8'h10 then 8'h80 presented during last beat -> same-cycle accept, next cycle addr=7, no bubble.
//  5 match_vec=8'hFF, drop rst after 3 beats -> out_valid=0 immediately, in_ready=1 after release.
//  6 MATCH_COUNT_EN: match_vec=8'hFF -> match_count=8 on all 8 beats; 8'h00 -> match_count=0.

Source files
------------

// File: rtl/cam_match_iterator_if.sv
// ---------------------------------------------------------------------------
// Module   : cam_match_iterator_if
// Purpose  : Match-vector input handshake and row-index output handshake
//            between the CAM match decoder, the iterator and the readout logic.
// Config   : MATCH_COUNT_EN adds the match_count signal.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface cam_match_iterator_if #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CAM_DEPTH-1:0]  match_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_hit;
  logic                  out_last;
`ifdef MATCH_COUNT_EN
  logic [ADDR_WIDTH:0]   match_count;
`endif

  // Producer of match vectors and consumer of row indices
  modport master (
    output in_valid, match_vec, out_ready,
    input  in_ready, out_valid, out_addr, out_hit, out_last
`ifdef MATCH_COUNT_EN
    , input match_count
`endif
  );

  // The iterator itself
  modport slave (
    input  in_valid, match_vec, out_ready,
    output in_ready, out_valid, out_addr, out_hit, out_last
`ifdef MATCH_COUNT_EN
    , output match_count
`endif
  );
endinterface

`default_nettype wire

// File: rtl/cam_match_iterator.sv
// ---------------------------------------------------------------------------
// Module   : cam_match_iterator
// Purpose  : Walks a multi-hot CAM match vector and emits each matching row
//            index, lowest first, one beat per handshake, last beat flagged.
//            An all-zero vector yields a single miss beat.
// Config   : MATCH_COUNT_EN - registered popcount of the accepted vector.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cam_match_iterator #(
  parameter int CAM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  wire                    clk,
  input  wire                    rst,   // asynchronous, active-low
  cam_match_iterator_if.slave    bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [CAM_DEPTH-1:0]  r_pending;
  logic                  r_miss;

  logic                  w_scan;
  logic [CAM_DEPTH-1:0]  w_rest;      // pending with its lowest set bit removed
  logic [ADDR_WIDTH-1:0] w_low_idx;
  logic                  w_beat;
  logic                  w_done;
  logic                  w_in_ready;
  logic                  w_accept;

  assign w_scan     = (r_state == S_SCAN);
  assign w_rest     = r_pending & (r_pending - CAM_DEPTH'(1));
  assign w_beat     = w_scan & bus.out_ready;
  assign w_done     = w_beat & (w_rest == '0);
  assign w_in_ready = ~w_scan | w_done;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Priority encode the lowest pending row (scan downward so the lowest wins)
  always_comb begin
    w_low_idx = '0;
    for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
      if (r_pending[i]) w_low_idx = i[ADDR_WIDTH-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state: a same-cycle accept on the last beat keeps us scanning
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)    w_state_nxt = S_SCAN;
    else if (w_done) w_state_nxt = S_IDLE;
  end

  // Pending row set and miss flag: load on accept, drop the emitted row per beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_miss    <= 1'b0;
    end else if (w_accept) begin
      r_pending <= bus.match_vec;
      r_miss    <= (bus.match_vec == '0);
    end else if (w_beat) begin
      r_pending <= w_rest;
    end
  end

  // Outputs decode from registers only; all beat fields read 0 while idle.
  // A non-miss vector never leaves pending empty while scanning, so the
  // registered miss flag is equivalent to ~|pending here.
  always_comb begin
    bus.out_valid = w_scan;
    bus.out_addr  = w_scan ? w_low_idx : '0;
    bus.out_hit   = w_scan & ~r_miss;
    bus.out_last  = w_scan & (w_rest == '0);
    bus.in_ready  = w_in_ready;
  end

`ifdef MATCH_COUNT_EN
  logic [ADDR_WIDTH:0] w_pop;
  logic [ADDR_WIDTH:0] r_count;

  // Popcount of the incoming vector
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      w_pop = w_pop + {{ADDR_WIDTH{1'b0}}, bus.match_vec[i]};
    end
  end

  // Count register: held for every beat of a vector, cleared when going idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_count <= '0;
    else if (w_accept) r_count <= w_pop;
    else if (w_done)   r_count <= '0;
  end

  assign bus.match_count = r_count;
`endif

endmodule

`default_nettype wire
